pre_if_align_buf: RTL and testbench
===================================

PRE_IF_ALIGN_BUF -- requirements
Module: pre_if_align_buf

Interface
REQ-001 SHALL have parameter FETCH_W, default 32, fetch word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 8, queue capacity in 16-bit parcels; must be a power of 2 and >= 2*FETCH_W/16.
REQ-003 SHALL have parameter EXPAND, default 1; 1 routes compressed parcels through c_instruction_expander, 0 emits them zero-extended.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 fetch_valid_i  input  1  fetch word and address are valid.
REQ-007 fetch_ready_o  output  1  block accepts the fetch word this cycle.
REQ-008 fetch_addr_i  input  32  byte address of the first wanted parcel; bit 0 is ignored.
REQ-009 fetch_data_i  input  FETCH_W  fetch word, naturally aligned, little-endian parcels.
REQ-010 flush_i  input  1  discard all queued parcels (jump or exception).
REQ-011 inst_valid_o  output  1  a complete instruction is at the queue head.
REQ-012 inst_ready_i  input  1  consumer takes the head instruction.
REQ-013 inst_o  output  32  instruction, expanded or zero-extended per EXPAND.
REQ-014 inst_addr_o  output  32  PC of inst_o.
REQ-015 is_compressed_o  output  1  head instruction is 16-bit (raw bits[1:0] != 2'b11).
REQ-016 ram_stall_valid_if_o  output  1  equals !inst_valid_o.
REQ-017 occupancy_o  output  log2(DEPTH)+1  current parcel count.

Function
REQ-018 Parcel offset SHALL be off = fetch_addr_i[log2(FETCH_W/8)-1:1]; a push SHALL enqueue parcels off..FETCH_W/16-1 in ascending order, i.e. FETCH_W/16-off parcels.
REQ-019 fetch_ready_o SHALL be 1 when DEPTH - occupancy >= FETCH_W/16 and flush_i is 0; it uses the start-of-cycle occupancy and ignores a same-cycle pop.
REQ-020 A push SHALL occur on fetch_valid_i && fetch_ready_o.
REQ-021 A pop SHALL occur on inst_valid_o && inst_ready_i && !flush_i; it removes 1 parcel if compressed and 2 otherwise.
REQ-022 inst_valid_o SHALL be 1 when occupancy >= 2, or when occupancy == 1 and the head parcel bits[1:0] != 2'b11.
REQ-023 With one uncompressed parcel queued, inst_valid_o SHALL stay 0 until its upper half arrives; the straddled instruction is then emitted as one 32-bit word.
REQ-024 inst_o raw value SHALL be {parcel[head+1], parcel[head]} for 32-bit instructions and {16'b0, parcel[head]} for compressed ones, before optional expansion.
REQ-025 Outputs SHALL be combinational from queue state only; a word pushed in cycle t SHALL be visible at inst_o in cycle t+1, so latency is 1.
REQ-026 Head PC register: a push into an empty queue (after any same-cycle pop) SHALL load fetch_addr_i with bit 0 cleared; otherwise each pop SHALL advance it by 2 or 4, modulo 2^32.
REQ-027 Head/tail pointers SHALL wrap modulo DEPTH; parcel index head+1 SHALL wrap likewise.
REQ-028 Simultaneous push and pop SHALL give next occupancy = occupancy + pushed - popped.
REQ-029 Flush SHALL have top priority: occupancy becomes 0, head and tail reset to 0, and any same-cycle push or pop is discarded.
REQ-030 Occupancy SHALL never exceed DEPTH nor go below 0 under any legal input sequence.

Reset
REQ-031 While rst == 0: occupancy, head, tail and head PC SHALL be 0; inst_valid_o = 0; ram_stall_valid_if_o = 1; fetch_ready_o = 1; occupancy_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all queued parcels immediately, without waiting for a clock edge.

Verification
REQ-033 Sequence: FETCH_W=32; push addr 0x80000000, data 0x00A00093 -> next cycle inst_valid_o=1, inst_o=0x00A00093, inst_addr_o=0x80000000, is_compressed_o=0.
REQ-034 Sequence: push addr 0x80000000, data 0x00930505 -> 0x0505 emitted at 0x80000000 with is_compressed_o=1, then 0x0093 parcel held and inst_valid_o=0; push 0x80000004, data 0x123400A0 -> inst_o raw 0x00A00093 at 0x80000002.
REQ-035 Sequence: push addr 0x80000002 (off=1) with data 0x4501FFFF -> only 0x4501 enqueued, occupancy_o=1, inst_addr_o=0x80000002.
REQ-036 Sequence: FETCH_W=32, DEPTH=8; inst_ready_i=0, push four words -> occupancy_o=8 and fetch_ready_o=0; one 32-bit pop -> occupancy_o=6 and fetch_ready_o=1 in the following cycle.
REQ-037 Sequence: occupancy 5, flush_i=1 with push and pop both requested -> next cycle occupancy_o=0, inst_valid_o=0; push addr 0x80001000 -> inst_addr_o=0x80001000.
REQ-038 Sequence: drive rst low for 3 cycles during continuous push and pop traffic -> all REQ-031 values hold during reset; after release, the first push is emitted from head index 0.

Source files
------------

// File: rtl/pre_if_align_buf.sv
// Fetch alignment queue: turns fetch words into whole RV32 instructions,
// splitting compressed parcels and joining instructions that straddle words.

module c_instruction_expander (
    input  logic [15:0] c_i,
    output logic [31:0] inst_o
);
    logic [15:0] c;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs1p;
    logic [11:1] j;

    assign c    = c_i;
    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[4:2]};
    assign rs1p = {2'b01, c[9:7]};
    assign j    = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};

    // Unsupported or reserved encodings expand to all-zero (an illegal word)
    always_comb begin
        inst_o = 32'h0;
        case ({c[15:13], c[1:0]})
            5'b000_00: if (c[12:5] != 8'h0)
                inst_o = {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00,
                          5'd2, 3'b000, rdp, 7'h13};
            5'b010_00: inst_o = {5'b0, c[5], c[12:10], c[6], 2'b00,
                                 rs1p, 3'b010, rdp, 7'h03};
            5'b110_00: inst_o = {5'b0, c[5], c[12], rdp, rs1p, 3'b010,
                                 c[11:10], c[6], 2'b00, 7'h23};
            5'b000_01: inst_o = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000,
                                 rd, 7'h13};
            5'b001_01: inst_o = {j[11], j[10:1], j[11], {8{j[11]}},
                                 5'd1, 7'h6f};
            5'b010_01: inst_o = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000,
                                 rd, 7'h13};
            5'b011_01: begin
                if (rd == 5'd2)
                    inst_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0,
                              5'd2, 3'b000, 5'd2, 7'h13};
                else
                    inst_o = {{15{c[12]}}, c[6:2], rd, 7'h37};
            end
            5'b100_01: begin
                case (c[11:10])
                    2'b00: inst_o = {7'b0, c[6:2], rs1p, 3'b101,
                                     rs1p, 7'h13};
                    2'b01: inst_o = {7'b0100000, c[6:2], rs1p, 3'b101,
                                     rs1p, 7'h13};
                    2'b10: inst_o = {{6{c[12]}}, c[12], c[6:2], rs1p,
                                     3'b111, rs1p, 7'h13};
                    default: begin
                        if (!c[12]) begin
                            case (c[6:5])
                                2'b00: inst_o = {7'b0100000, rdp, rs1p,
                                                 3'b000, rs1p, 7'h33};
                                2'b01: inst_o = {7'b0, rdp, rs1p, 3'b100,
                                                 rs1p, 7'h33};
                                2'b10: inst_o = {7'b0, rdp, rs1p, 3'b110,
                                                 rs1p, 7'h33};
                                default: inst_o = {7'b0, rdp, rs1p, 3'b111,
                                                   rs1p, 7'h33};
                            endcase
                        end
                    end
                endcase
            end
            5'b101_01: inst_o = {j[11], j[10:1], j[11], {8{j[11]}},
                                 5'd0, 7'h6f};
            5'b110_01,
            5'b111_01: inst_o = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p,
                                 2'b00, c[13], c[11:10], c[4:3], c[12],
                                 7'h63};
            5'b000_10: inst_o = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
            5'b010_10: inst_o = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                                 5'd2, 3'b010, rd, 7'h03};
            5'b100_10: begin
                if (!c[12]) begin
                    if (rs2 == 5'd0)
                        inst_o = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                    else
                        inst_o = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                end else begin
                    if (rd == 5'd0 && rs2 == 5'd0)
                        inst_o = 32'h0010_0073;
                    else if (rs2 == 5'd0)
                        inst_o = {12'b0, rd, 3'b000, 5'd1, 7'h67};
                    else
                        inst_o = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                end
            end
            5'b110_10: inst_o = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                                 c[11:9], 2'b00, 7'h23};
            default: inst_o = 32'h0;
        endcase
    end
endmodule

module pre_if_align_buf #(
    parameter int unsigned FETCH_W = 32,
    parameter int unsigned DEPTH   = 8,
    parameter bit          EXPAND  = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [31:0]              fetch_addr_i,
    input  logic [FETCH_W-1:0]       fetch_data_i,
    input  logic                     flush_i,
    output logic                     inst_valid_o,
    input  logic                     inst_ready_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              inst_addr_o,
    output logic                     is_compressed_o,
    output logic                     ram_stall_valid_if_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);
    localparam int unsigned NP = FETCH_W / 16;
    localparam int unsigned OW = $clog2(NP);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [15:0]        mem [DEPTH];
    ptr_t               head;
    ptr_t               tail;
    cnt_t               cnt;
    logic [31:0]        head_pc;

    logic [OW-1:0]      off;
    logic [FETCH_W-1:0] shifted;
    cnt_t               push_n;
    cnt_t               pop_n;
    cnt_t               cnt_pop;
    logic [15:0]        h0;
    logic [15:0]        h1;
    logic               is_c;
    logic               push;
    logic               pop;
    logic [31:0]        raw;
    logic [31:0]        expanded;

    assign off     = fetch_addr_i[OW:1];
    assign shifted = fetch_data_i >> {off, 4'b0};
    assign push_n  = cnt_t'(NP) - cnt_t'(off);

    assign h0   = mem[head];
    assign h1   = mem[head + ptr_t'(1)];
    assign is_c = h0[1:0] != 2'b11;

    assign inst_valid_o  = (cnt >= cnt_t'(2)) || (cnt == cnt_t'(1) && is_c);
    assign fetch_ready_o = ((cnt_t'(DEPTH) - cnt) >= cnt_t'(NP)) && !flush_i;

    assign push    = fetch_valid_i && fetch_ready_o;
    assign pop     = inst_valid_o && inst_ready_i && !flush_i;
    assign pop_n   = is_c ? cnt_t'(1) : cnt_t'(2);
    assign cnt_pop = pop ? cnt - pop_n : cnt;

    assign raw = is_c ? {16'b0, h0} : {h1, h0};

    c_instruction_expander u_exp (
        .c_i    (h0),
        .inst_o (expanded)
    );

    assign inst_o               = (EXPAND && is_c) ? expanded : raw;
    assign inst_addr_o          = head_pc;
    assign is_compressed_o      = is_c;
    assign ram_stall_valid_if_o = !inst_valid_o;
    assign occupancy_o          = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            head    <= '0;
            tail    <= '0;
            head_pc <= '0;
        end else if (flush_i) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            cnt <= cnt_pop + (push ? push_n : '0);
            if (pop)
                head <= head + ptr_t'(pop_n);
            if (push)
                tail <= tail + ptr_t'(push_n);
            // A word landing in a drained queue defines the new head PC
            if (push && cnt_pop == '0)
                head_pc <= fetch_addr_i & ~32'd1;
            else if (pop)
                head_pc <= head_pc + (is_c ? 32'd2 : 32'd4);
        end
    end

    // Parcel storage needs no reset: occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            for (int j = 0; j < NP; j++) begin
                if (cnt_t'(j) < push_n)
                    mem[tail + ptr_t'(j)] <= shifted[j*16 +: 16];
            end
        end
    end
endmodule

// File: tb/tb_pre_if_align_buf.sv
// Directed bench for pre_if_align_buf with FETCH_W=32, DEPTH=8, EXPAND=1.

module tb_pre_if_align_buf;
    logic        clk;
    logic        rst;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_addr_i;
    logic [31:0] fetch_data_i;
    logic        flush_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        is_compressed_o;
    logic        ram_stall_valid_if_o;
    logic [3:0]  occupancy_o;

    int n_vec;
    int n_err;

    pre_if_align_buf #(
        .FETCH_W (32),
        .DEPTH   (8),
        .EXPAND  (1'b1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_valid_i        (fetch_valid_i),
        .fetch_ready_o        (fetch_ready_o),
        .fetch_addr_i         (fetch_addr_i),
        .fetch_data_i         (fetch_data_i),
        .flush_i              (flush_i),
        .inst_valid_o         (inst_valid_o),
        .inst_ready_i         (inst_ready_i),
        .inst_o               (inst_o),
        .inst_addr_o          (inst_addr_o),
        .is_compressed_o      (is_compressed_o),
        .ram_stall_valid_if_o (ram_stall_valid_if_o),
        .occupancy_o          (occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d);
        fetch_valid_i = 1'b1;
        fetch_addr_i  = a;
        fetch_data_i  = d;
    endtask

    task automatic pop1();
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_occ"},   32'(occupancy_o), 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        chk({tag, "_stall"}, 32'(ram_stall_valid_if_o), 32'd1);
        chk({tag, "_rdy"},   32'(fetch_ready_o), 32'd1);
        chk({tag, "_pc"},    inst_addr_o, 32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_addr_i = '0;
        fetch_data_i = '0;
        flush_i = 1'b0;
        inst_ready_i = 1'b0;
        tick();
        tick();
        chk_reset("rst");
        rst = 1'b1;

        // single 32-bit instruction, latency 1
        drive(32'h8000_0000, 32'h00A0_0093);
        tick();
        fetch_valid_i = 1'b0;
        chk("w_valid", 32'(inst_valid_o), 32'd1);
        chk("w_inst",  inst_o, 32'h00A0_0093);
        chk("w_pc",    inst_addr_o, 32'h8000_0000);
        chk("w_cmp",   32'(is_compressed_o), 32'd0);
        pop1();
        chk("w_occ0",  32'(occupancy_o), 32'd0);

        // compressed head, then straddled word
        drive(32'h8000_0000, 32'h0093_0505);
        tick();
        fetch_valid_i = 1'b0;
        chk("c_cmp",  32'(is_compressed_o), 32'd1);
        chk("c_inst", inst_o, 32'h0015_0513);
        chk("c_pc",   inst_addr_o, 32'h8000_0000);
        pop1();
        chk("h_valid", 32'(inst_valid_o), 32'd0);
        chk("h_occ",   32'(occupancy_o), 32'd1);
        chk("h_pc",    inst_addr_o, 32'h8000_0002);
        drive(32'h8000_0004, 32'h1234_00A0);
        tick();
        fetch_valid_i = 1'b0;
        chk("s_valid", 32'(inst_valid_o), 32'd1);
        chk("s_inst",  inst_o, 32'h00A0_0093);
        chk("s_pc",    inst_addr_o, 32'h8000_0002);
        chk("s_cmp",   32'(is_compressed_o), 32'd0);
        chk("s_occ",   32'(occupancy_o), 32'd3);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("f_occ", 32'(occupancy_o), 32'd0);

        // odd parcel offset
        drive(32'h8000_0002, 32'h4501_FFFF);
        tick();
        fetch_valid_i = 1'b0;
        chk("o_occ",  32'(occupancy_o), 32'd1);
        chk("o_pc",   inst_addr_o, 32'h8000_0002);
        chk("o_inst", inst_o, 32'h0000_0513);
        chk("o_valid", 32'(inst_valid_o), 32'd1);
        pop1();

        // fill to capacity, then drain across the pointer wrap
        for (int k = 0; k < 4; k++) begin
            drive(32'h8000_0100 + 32'(4 * k), 32'h00A0_0093 + (32'(k) << 20));
            tick();
        end
        fetch_valid_i = 1'b0;
        chk("full_occ", 32'(occupancy_o), 32'd8);
        chk("full_rdy", 32'(fetch_ready_o), 32'd0);
        chk("full_inst", inst_o, 32'h00A0_0093);
        pop1();
        chk("dr_occ", 32'(occupancy_o), 32'd6);
        chk("dr_rdy", 32'(fetch_ready_o), 32'd1);
        for (int k = 1; k < 4; k++) begin
            chk("dr_inst", inst_o, 32'h00A0_0093 + (32'(k) << 20));
            chk("dr_pc", inst_addr_o, 32'h8000_0100 + 32'(4 * k));
            pop1();
        end
        chk("dr_end", 32'(occupancy_o), 32'd0);

        // push into a queue emptied by the same-cycle pop
        drive(32'h8000_1000, 32'h00A0_0093);
        tick();
        chk("pp_occ0", 32'(occupancy_o), 32'd2);
        drive(32'h8000_2000, 32'h00B0_0093);
        inst_ready_i = 1'b1;
        tick();
        fetch_valid_i = 1'b0;
        inst_ready_i = 1'b0;
        chk("pp_occ", 32'(occupancy_o), 32'd2);
        chk("pp_pc",  inst_addr_o, 32'h8000_2000);
        chk("pp_inst", inst_o, 32'h00B0_0093);

        // flush beats a same-cycle push and pop
        drive(32'h8000_0202, 32'h4501_0000);
        tick();
        drive(32'h8000_0300, 32'h00C0_0093);
        tick();
        chk("fl_occ5", 32'(occupancy_o), 32'd5);
        flush_i = 1'b1;
        inst_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        inst_ready_i = 1'b0;
        fetch_valid_i = 1'b0;
        chk("fl_occ",   32'(occupancy_o), 32'd0);
        chk("fl_valid", 32'(inst_valid_o), 32'd0);
        drive(32'h8000_1000, 32'h00D0_0093);
        tick();
        fetch_valid_i = 1'b0;
        chk("fl_pc", inst_addr_o, 32'h8000_1000);
        chk("fl_inst", inst_o, 32'h00D0_0093);
        pop1();

        // asynchronous reset under streaming traffic
        drive(32'h8000_3000, 32'h00A0_0093);
        inst_ready_i = 1'b1;
        tick();
        tick();
        tick();
        chk("st_occ", 32'(occupancy_o), 32'd2);
        #3;
        rst = 1'b0;
        #1;
        chk_reset("ar");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_hold_occ", 32'(occupancy_o), 32'd0);
            chk("ar_hold_vld", 32'(inst_valid_o), 32'd0);
        end
        fetch_valid_i = 1'b0;
        inst_ready_i = 1'b0;
        rst = 1'b1;
        drive(32'h8000_4000, 32'h00E0_0093);
        tick();
        fetch_valid_i = 1'b0;
        chk("pr_inst", inst_o, 32'h00E0_0093);
        chk("pr_pc",   inst_addr_o, 32'h8000_4000);
        chk("pr_occ",  32'(occupancy_o), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
